// File: rtl/arb_pkg.sv
// Shared constants and types for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [NREQ-1:0] onehot4(input logic [IDW-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational cyclic-priority picker: first eligible request scanning ptr, ptr+1, ... mod 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic [NREQ-1:0] mask,
    output logic            valid,
    output logic [IDW-1:0]  idx
);

    logic [NREQ-1:0] elig;
    logic [IDW-1:0]  cand;

    assign elig = req & ~mask;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // Index arithmetic is IDW bits wide, so 3 -> 0 wraps for free.
            cand = ptr + IDW'(k);
            if (!valid && (elig[cand] == 1'b1)) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// Round-robin arbiter/controller for four requesters sharing one resource.
// Optional grant-length timeout is compiled in with `define ARB_TIMEOUT_EN.
module rr_arb4_ctrl
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CW       = 4
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            En,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic            timeout
);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;

    logic [IDW-1:0]  pick_ptr;
    logic [NREQ-1:0] pick_mask;
    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;

    logic            owner_req;
    logic            other_rel;
    logic            hold_hit;
    logic            rel;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_req = (req[gnt_id_q] == 1'b1);
    assign other_rel = done || !owner_req || !En;
    assign rel       = (state_q == GRANT) && (other_rel || hold_hit);

    // In GRANT the picker always looks at the post-release pointer with the
    // owner masked; its result is only used when a release actually happens.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        pick_ptr  = ptr_q;
        pick_mask = '0;

        unique case (state_q)
            IDLE: begin
                if (En && pick_valid) begin
                    state_d  = GRANT;
                    gnt_id_d = pick_idx;
                    gnt_d    = onehot4(pick_idx);
                end
            end
            GRANT: begin
                pick_ptr  = gnt_id_q + 2'd1;
                pick_mask = onehot4(gnt_id_q);
                if (rel) begin
                    ptr_d = gnt_id_q + 2'd1;
                    if (En && pick_valid) begin
                        gnt_id_d = pick_idx;
                        gnt_d    = onehot4(pick_idx);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    assign hold_hit  = (state_q == GRANT) && (cnt_q == CW'(HOLD_MAX));
    assign timeout_d = hold_hit && !other_rel;
    // Counter restarts on every release (new owner or IDLE), counts held cycles.
    assign cnt_d     = ((state_q == GRANT) && !rel) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_cfg;

    assign hold_hit   = 1'b0;
    assign timeout    = 1'b0;
    assign unused_cfg = ^{HOLD_MAX, CW};
`endif

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Directed plus randomized bench for rr_arb4_ctrl against a behavioural arbiter model.
module tb_rr_arb4_ctrl;

    localparam int HOLD = 3;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       En;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    // Model: owner index (-1 = nobody), last owner, priority start, cycles held.
    int m_owner, m_last, m_ptr, m_hold;
    bit m_to;

    rr_arb4_ctrl #(.HOLD_MAX(HOLD), .CW(4)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .En      (En),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 Clock = ~Clock;

    task automatic m_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    task automatic m_search(input bit [3:0] r, input int skip);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (j != skip && r[j]) begin
                m_owner = j;
                m_last  = j;
                m_hold  = 0;
                return;
            end
        end
    endtask

    task automatic m_step(input bit en, input bit [3:0] r, input bit d);
        if (m_owner < 0) begin
            m_to = 1'b0;
            if (en) m_search(r, -1);
        end else begin
            bit other;
            bit tmo;
            int prev;
            other = d || !r[m_owner] || !en;
            tmo   = TMO_EN && (m_hold == HOLD) && !other;
            if (other || tmo) begin
                prev    = m_owner;
                m_ptr   = (prev + 1) % 4;
                m_owner = -1;
                m_to    = tmo;
                if (en) m_search(r, prev);
            end else begin
                m_hold = m_hold + 1;
                m_to   = 1'b0;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [3:0] eg;
        logic [1:0] eid;
        logic       eb;
        eg  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        eid = 2'(m_last);
        eb  = (m_owner >= 0);
        checks++;
        assert (gnt === eg) else begin
            failures++;
            $error("FAIL %s gnt got=%b exp=%b", tag, gnt, eg);
        end
        checks++;
        assert (gnt_id === eid) else begin
            failures++;
            $error("FAIL %s gnt_id got=%0d exp=%0d", tag, gnt_id, eid);
        end
        checks++;
        assert (busy === eb) else begin
            failures++;
            $error("FAIL %s busy got=%b exp=%b", tag, busy, eb);
        end
        checks++;
        assert (timeout === m_to) else begin
            failures++;
            $error("FAIL %s timeout got=%b exp=%b", tag, timeout, m_to);
        end
    endtask

    task automatic expect_gnt(input string tag, input logic [3:0] exp);
        checks++;
        assert (gnt === exp) else begin
            failures++;
            $error("FAIL %s gnt got=%b exp=%b", tag, gnt, exp);
        end
    endtask

    task automatic expect_id(input string tag, input logic [1:0] exp);
        checks++;
        assert (gnt_id === exp) else begin
            failures++;
            $error("FAIL %s gnt_id got=%0d exp=%0d", tag, gnt_id, exp);
        end
    endtask

    task automatic expect_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic cycle(input bit en, input bit [3:0] r, input bit d, input string tag);
        En   = en;
        req  = r;
        done = d;
        @(posedge Clock);
        m_step(en, r, d);
        #1;
        check(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic rst_pulse(input string tag);
        req  = 4'b0000;
        done = 1'b0;
        #3 Resetn = 1'b0;
        #1;
        m_reset();
        expect_gnt({tag, "_gnt"}, 4'b0000);
        expect_bit({tag, "_busy"}, busy, 1'b0);
        check(tag);
        #1 Resetn = 1'b1;
    endtask

    initial begin
        logic [1:0] rr_order [4];
        rr_order = '{2'd1, 2'd2, 2'd3, 2'd0};

        Resetn = 1'b0;
        En     = 1'b0;
        req    = 4'b0000;
        done   = 1'b0;
        m_reset();
        #1;
        check("reset");
        repeat (2) @(posedge Clock);
        #1 Resetn = 1'b1;

        // Basic grant, then reset mid-grant, then grant again.
        cycle(1'b1, 4'b0100, 1'b0, "basic");
        expect_gnt("basic_gnt", 4'b0100);
        expect_id("basic_id", 2'd2);
        rst_pulse("rst_mid");
        cycle(1'b1, 4'b0100, 1'b0, "post_rst");
        expect_gnt("post_rst_gnt", 4'b0100);

        // Round-robin with done each grant: 0,1,2,3,0 without bubbles.
        rst_pulse("rst_rr");
        cycle(1'b1, 4'b1111, 1'b0, "rr_first");
        expect_id("rr_first_id", 2'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'b1111, 1'b1, "rr_step");
            expect_id("rr_order", rr_order[i]);
            expect_bit("rr_nobubble", busy, 1'b1);
        end

        // Lone persistent requester: one IDLE cycle, then re-grant.
        cycle(1'b1, 4'b0001, 1'b1, "mask_rel");
        expect_gnt("mask_idle", 4'b0000);
        cycle(1'b1, 4'b0001, 1'b0, "mask_regnt");
        expect_gnt("mask_regnt_gnt", 4'b0001);

        // Owner drops its request; then En falls mid-grant.
        cycle(1'b1, 4'b0100, 1'b1, "to_owner2");
        expect_gnt("to_owner2_gnt", 4'b0100);
        cycle(1'b1, 4'b1000, 1'b0, "drop");
        expect_gnt("drop_gnt", 4'b1000);
        cycle(1'b0, 4'b1000, 1'b0, "en_off");
        expect_gnt("en_off_gnt", 4'b0000);
        expect_bit("en_off_busy", busy, 1'b0);

        // done together with new requests: ptr=2 beats requester 0.
        cycle(1'b1, 4'b0010, 1'b0, "sim_own1");
        expect_gnt("sim_own1_gnt", 4'b0010);
        cycle(1'b1, 4'b0101, 1'b1, "simul");
        expect_gnt("simul_gnt", 4'b0100);

        // Long hold with no done: revoked only when the timeout is built.
        cycle(1'b1, 4'b0000, 1'b0, "to_idle");
        cycle(1'b1, 4'b0011, 1'b0, "hold_start");
        expect_gnt("hold_start_gnt", 4'b0001);
        for (int i = 0; i < 22; i++) begin
            cycle(1'b1, 4'b0011, 1'b0, "hold");
            if (TMO_EN && i == 3) begin
                expect_gnt("tmo_gnt", 4'b0010);
                expect_bit("tmo_pulse", timeout, 1'b1);
            end
        end
        if (!TMO_EN) begin
            expect_gnt("hold_keep_gnt", 4'b0001);
            expect_bit("hold_no_tmo", timeout, 1'b0);
        end

        // Randomized traffic with occasional long holds and enable drops.
        for (int i = 0; i < 500; i++) begin
            bit         en;
            bit [3:0]   r;
            bit         d;
            en = ($urandom_range(0, 11) != 0);
            r  = 4'($urandom);
            d  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) r = req;
            cycle(en, r, d, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
